// File: rtl/lc3b_fetch_unit.sv
// LC-3b instruction-fetch front end: owns the PC, runs the mem_read/mem_resp
// handshake and hands IR/PC to decode over a valid/ready interface.
module lc3b_fetch_unit #(
    parameter int unsigned     WIDTH      = 16,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned     PC_INC     = 2,
    parameter int unsigned     ALIGN_BITS = 1,
    parameter int unsigned     CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] mem_address,
    output logic             mem_read,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_resp,
    output logic [WIDTH-1:0] ir,
    output logic [WIDTH-1:0] ir_pc,
    output logic             ir_valid,
    input  logic             ir_ready,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_target,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ALIGN_MASK =
        ~((WIDTH'(1) << ALIGN_BITS) - WIDTH'(1));

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pending_target;
    logic             pending;

    function automatic logic [WIDTH-1:0] align_target(input logic [WIDTH-1:0] t);
        return t & ALIGN_MASK;
    endfunction

    // Outputs decode straight from state/pc, so nothing combinational leaks
    // from inputs to outputs.
    assign mem_read    = (state == FETCH);
    assign ir_valid    = (state == HOLD);
    assign mem_address = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= START;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            START: state_next = FETCH;
            FETCH: begin
                if (mem_resp) begin
                    state_next = (pending || redirect) ? START : HOLD;
                end
            end
            HOLD: begin
                if (ir_ready || redirect) begin
                    state_next = FETCH;
                end
            end
            default: state_next = START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            ir             <= '0;
            ir_pc          <= '0;
            pending        <= 1'b0;
            pending_target <= '0;
            fetch_count    <= '0;
        end else begin
            case (state)
                START: begin
                    if (redirect) begin
                        pc <= align_target(redirect_target);
                    end
                end
                FETCH: begin
                    // A redirect seen while the request is outstanding only
                    // takes effect once memory completes; the stale data is dropped.
                    if (mem_resp) begin
                        if (redirect) begin
                            pc <= align_target(redirect_target);
                        end else if (pending) begin
                            pc <= pending_target;
                        end else begin
                            ir    <= mem_rdata;
                            ir_pc <= pc;
                            pc    <= pc + WIDTH'(PC_INC);
                        end
                        pending <= 1'b0;
                    end else if (redirect) begin
                        pending        <= 1'b1;
                        pending_target <= align_target(redirect_target);
                    end
                end
                HOLD: begin
                    if (ir_ready) begin
                        fetch_count <= fetch_count + CNT_W'(1);
                    end
                    if (redirect) begin
                        pc <= align_target(redirect_target);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3b_fetch_unit.sv
// Bench for lc3b_fetch_unit: directed scenarios followed by a randomized run
// checked against a transaction-level model of the fetch stream.
module tb_lc3b_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mem_address;
    logic        mem_read;
    logic [15:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_target = '0;
    logic [15:0] fetch_count;

    int n_cmp = 0;
    int n_bad = 0;

    lc3b_fetch_unit dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_address(mem_address),
        .mem_read(mem_read),
        .mem_rdata(mem_rdata),
        .mem_resp(mem_resp),
        .ir(ir),
        .ir_pc(ir_pc),
        .ir_valid(ir_valid),
        .ir_ready(ir_ready),
        .redirect(redirect),
        .redirect_target(redirect_target),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Random-phase model state
    logic [15:0] pred_addr, cur_req, latched_pc, exp_cnt;
    logic        prev_rd, req_redir, exp_valid;
    logic        rd, rdy, rsp;
    logic [15:0] rt;
    int          wait_cnt, lat;

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_addr", mem_address, 16'h0000);
        chk("rst_ir", ir, 0);
        chk("rst_ir_pc", ir_pc, 0);
        chk("rst_count", fetch_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req", mem_read, 1);
        chk("first_addr", mem_address, 16'h0000);

        // Single-cycle memory, consumer ready
        mem_resp = 1'b1; mem_rdata = 16'h1234; ir_ready = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        chk("t1_valid", ir_valid, 1);
        chk("t1_ir", ir, 16'h1234);
        chk("t1_ir_pc", ir_pc, 16'h0000);
        chk("t1_mem_read", mem_read, 0);
        @(negedge clk);
        chk("t1_next_addr", mem_address, 16'h0002);
        chk("t1_count", fetch_count, 1);

        // Back-pressure in HOLD for 5 cycles
        mem_resp = 1'b1; mem_rdata = 16'hABCD; ir_ready = 1'b0;
        @(negedge clk);
        mem_resp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_valid", ir_valid, 1);
            chk("t2_ir", ir, 16'hABCD);
            chk("t2_ir_pc", ir_pc, 16'h0002);
            chk("t2_mem_read", mem_read, 0);
            chk("t2_count", fetch_count, 1);
            @(negedge clk);
        end
        ir_ready = 1'b1;
        @(negedge clk);
        ir_ready = 1'b0;
        chk("t2_count_after", fetch_count, 2);
        chk("t2_next_addr", mem_address, 16'h0004);
        chk("t2_mem_read_after", mem_read, 1);

        // 4-cycle memory with redirect in the second FETCH cycle
        @(negedge clk);
        redirect = 1'b1; redirect_target = 16'h3001;
        @(negedge clk);
        redirect = 1'b0;
        chk("t3_addr_held_a", mem_address, 16'h0004);
        chk("t3_mem_read", mem_read, 1);
        @(negedge clk);
        chk("t3_addr_held_b", mem_address, 16'h0004);
        mem_resp = 1'b1; mem_rdata = 16'hDEAD; ir_ready = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0; ir_ready = 1'b0;
        chk("t3_gap_read", mem_read, 0);
        chk("t3_gap_valid", ir_valid, 0);
        @(negedge clk);
        chk("t3_new_addr", mem_address, 16'h3000);
        chk("t3_new_read", mem_read, 1);
        chk("t3_count", fetch_count, 2);

        // Redirect in HOLD without ready
        mem_resp = 1'b1; mem_rdata = 16'h5555;
        @(negedge clk);
        mem_resp = 1'b0;
        chk("t4_valid", ir_valid, 1);
        chk("t4_ir", ir, 16'h5555);
        chk("t4_ir_pc", ir_pc, 16'h3000);
        redirect = 1'b1; redirect_target = 16'h0400;
        @(negedge clk);
        redirect = 1'b0;
        chk("t4_valid_drop", ir_valid, 0);
        chk("t4_mem_read", mem_read, 1);
        chk("t4_addr", mem_address, 16'h0400);
        chk("t4_count", fetch_count, 2);

        // Redirect coinciding with mem_resp, then fetch at the top of memory
        mem_resp = 1'b1; redirect = 1'b1; redirect_target = 16'hFFFF; mem_rdata = 16'hBEEF;
        @(negedge clk);
        mem_resp = 1'b0; redirect = 1'b0;
        chk("t5_start", mem_read, 0);
        @(negedge clk);
        chk("t5_addr", mem_address, 16'hFFFE);
        mem_resp = 1'b1; mem_rdata = 16'h7777; ir_ready = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        chk("t5_ir", ir, 16'h7777);
        chk("t5_ir_pc", ir_pc, 16'hFFFE);
        @(negedge clk);
        ir_ready = 1'b0;
        chk("t5_wrap_addr", mem_address, 16'h0000);
        chk("t5_count", fetch_count, 3);

        // Reset during an outstanding fetch, then a stale response
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_read", mem_read, 0);
        chk("t6_rst_valid", ir_valid, 0);
        chk("t6_rst_addr", mem_address, 16'h0000);
        chk("t6_rst_count", fetch_count, 0);
        @(negedge clk);
        rst_n = 1'b1; mem_resp = 1'b1; mem_rdata = 16'h0BAD;
        @(negedge clk);
        mem_resp = 1'b0;
        chk("t6_stale_ignored", ir_valid, 0);
        chk("t6_req", mem_read, 1);
        chk("t6_addr", mem_address, 16'h0000);
        mem_resp = 1'b1; mem_rdata = 16'h4321; ir_ready = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        chk("t6_ir", ir, 16'h4321);
        chk("t6_ir_pc", ir_pc, 16'h0000);
        @(negedge clk);
        ir_ready = 1'b0;
        chk("t6_count", fetch_count, 1);
        chk("t6_next_addr", mem_address, 16'h0002);

        // Randomized run: every transfer must carry memory's word for its PC,
        // and each new request must start at the predicted fetch address.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pred_addr = 16'h0000; cur_req = '0; latched_pc = '0; exp_cnt = '0;
        prev_rd = 1'b0; req_redir = 1'b0; exp_valid = 1'b0;
        wait_cnt = 0; lat = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (mem_read && !prev_rd) begin
                chk("r_req_addr", mem_address, pred_addr);
                cur_req = mem_address; req_redir = 1'b0;
                wait_cnt = 0; lat = $urandom_range(0, 3);
            end else if (mem_read) begin
                chk("r_addr_stable", mem_address, cur_req);
            end
            chk("r_valid", ir_valid, exp_valid);
            chk("r_count", fetch_count, exp_cnt);
            if (ir_valid) begin
                chk("r_ir", ir, memf(ir_pc));
                chk("r_ir_pc", ir_pc, latched_pc);
            end

            rd  = ($urandom_range(0, 99) < 8);
            rt  = 16'($urandom);
            rdy = ($urandom_range(0, 99) < 60);
            rsp = mem_read ? (wait_cnt == lat) : ($urandom_range(0, 99) < 5);

            if (ir_valid && rdy) exp_cnt = exp_cnt + 16'd1;
            if (ir_valid && (rdy || rd)) exp_valid = 1'b0;
            if (mem_read && rsp && !rd && !req_redir) begin
                latched_pc = cur_req;
                pred_addr  = cur_req + 16'd2;
                exp_valid  = 1'b1;
            end
            if (rd) begin
                pred_addr = rt & 16'hFFFE;
                if (mem_read) req_redir = 1'b1;
            end
            if (mem_read && !rsp) wait_cnt++;
            prev_rd = mem_read;

            mem_rdata       = mem_read ? memf(mem_address) : 16'($urandom);
            mem_resp        = rsp;
            redirect        = rd;
            redirect_target = rt;
            ir_ready        = rdy;
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
